pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V core. It supersedes the dual-edge PC with a single rising-edge design.
- Produces the current and sequential fetch addresses. Supports four redirects:
  - PC-relative jump/branch
  - register-indirect jump (JALR)
  - return-address-stack (RAS) predicted return
  - trap vector
- Adds misalignment detection and a circular RAS of configurable depth.
- Sits between the control unit and instruction memory.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- IALIGN, 32, instruction alignment in bits: 32 gives STEP=4 and checks bits[1:0]; 16 gives STEP=2 and checks bit[0].
- RAS_DEPTH, 4, number of RAS entries (power of 2, ≥2).

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- pc_write  in  1  update enable; low holds the PC (stall).
- update_sel  in  3  0 STEP, 1 JP_R, 2 JP_F, 3 HOLD, 4 RET; 5-7 reserved.
- offset  in  XLEN  immediate used by JP_R.
- alu_f  in  XLEN  computed target used by JP_F and by the RET fallback.
- ras_push  in  1  current instruction is a call; push cur_inst_addr+STEP.
- trap_req  in  1  take a trap this cycle.
- trap_vec  in  XLEN  trap handler address.
- cur_inst_addr  out  XLEN  address of the instruction being fetched.
- next_inst_addr  out  XLEN  always cur_inst_addr+STEP.
- misalign_exc  out  1  one-cycle pulse: a redirect target was misaligned.
- misalign_addr  out  XLEN  offending target, held until the next misalign event.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - cur_inst_addr = RESET_VECTOR.
  - next_inst_addr = RESET_VECTOR+STEP.
  - misalign_exc = 0, misalign_addr = 0, ras_count = 0, RAS pointer = 0.
- Reset mid-operation discards any pending redirect.
- First fetch after reset release is at RESET_VECTOR; there is no pre-step.
- Target selection (combinational), all arithmetic modulo 2^XLEN with wrap-around, no carry-out:
  - STEP: cur+STEP.
  - JP_R: cur+offset.
  - JP_F: alu_f with bit0 cleared.
  - HOLD: cur.
  - RET: RAS top if ras_count>0, else alu_f with bit0 cleared.
  - Reserved codes: treated as HOLD.
- Priority each rising edge:
  1. trap_req=1: PC ← trap_vec, regardless of pc_write. trap_vec is not alignment-checked. RAS is untouched and ras_push/pop are ignored.
  2. Else pc_write=0: everything holds, including the RAS.
  3. Else target misaligned: PC holds, misalign_exc=1 next cycle, misalign_addr ← target, no RAS change.
  4. Else PC ← target.
- Latency: the new PC is visible one cycle after the edge that samples the request. misalign_exc lasts exactly one cycle unless re-triggered.
- RAS operations (only when priority step 4 applies):
  - push only (ras_push=1, sel≠RET): write cur+STEP at the pointer, pointer+1 mod RAS_DEPTH, ras_count saturates at RAS_DEPTH. When full, the oldest entry is overwritten.
  - pop only (sel=RET, ras_push=0, ras_count>0): pointer−1, ras_count−1.
  - pop with ras_count=0: no state change; the fallback target is used.
  - push+pop together (sel=RET, ras_push=1): target = old top, top entry replaced by cur+STEP, pointer and count unchanged. With an empty RAS this acts as a push of cur+STEP using the fallback target.
- next_inst_addr is registered alongside cur_inst_addr; it is never a stale value.

Test Plan:
- Reset release, then 3 cycles of STEP with pc_write=1 -> cur = 0x0, 0x4, 0x8, 0xC; next always cur+4.
- At cur=0x100: JP_R with offset=0xFFFFFFF0 -> cur=0xF0. Then JP_F with alu_f=0x203 -> misaligned: cur holds 0xF0, misalign_exc pulses once, misalign_addr=0x202.
- trap_req=1, pc_write=0, trap_vec=0x8000_0000 -> cur=0x8000_0000 next cycle, ras_count unchanged.
- RAS_DEPTH=4: five pushes from cur=0x10,0x20,0x30,0x40,0x50 with jumps between, then five RETs -> targets 0x54, 0x44, 0x34, 0x24, then empty, so the fifth RET uses alu_f; ras_count goes 4,3,2,1,0,0.
- pc_write=0 while ras_push=1 and sel=RET -> PC, ras_count and RAS contents all unchanged.
- cur=0xFFFF_FFFC with STEP -> cur=0x0 (wrap). Assert rst low mid-stall -> cur=RESET_VECTOR immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - control-unit to program-counter generator bus
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) ();
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            pc_write;
    logic [2:0]      update_sel;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] alu_f;
    logic            ras_push;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic [XLEN-1:0] cur_inst_addr;
    logic [XLEN-1:0] next_inst_addr;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;
    logic [CW-1:0]   ras_count;

    modport master (
        output pc_write, update_sel, offset, alu_f, ras_push, trap_req, trap_vec,
        input  cur_inst_addr, next_inst_addr, misalign_exc, misalign_addr, ras_count
    );

    modport slave (
        input  pc_write, update_sel, offset, alu_f, ras_push, trap_req, trap_vec,
        output cur_inst_addr, next_inst_addr, misalign_exc, misalign_addr, ras_count
    );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter generator with redirects, misalign check and circular RAS
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              IALIGN       = 32,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam int              PW     = $clog2(RAS_DEPTH);
    localparam int              CW     = PW + 1;
    localparam logic [XLEN-1:0] STEP_V = XLEN'(IALIGN / 8);
    // Low address bits that must be zero for an aligned instruction.
    localparam logic [XLEN-1:0] AMASK  = STEP_V - XLEN'(1);

    localparam logic [2:0] SEL_STEP = 3'd0;
    localparam logic [2:0] SEL_JP_R = 3'd1;
    localparam logic [2:0] SEL_JP_F = 3'd2;
    localparam logic [2:0] SEL_RET  = 3'd4;

    logic [XLEN-1:0] cur_q, cur_d;
    logic [XLEN-1:0] next_q, next_d;
    logic            exc_q, exc_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];

    logic [PW-1:0]   top_idx;
    logic            ras_empty;
    logic            is_ret;
    logic [XLEN-1:0] fallback;
    logic [XLEN-1:0] ret_addr;
    logic [XLEN-1:0] target;
    logic            misaligned;

    // Target selection and misalignment detection for the current request.
    always_comb begin
        top_idx    = ptr_q - PW'(1);
        ras_empty  = (count_q == '0);
        is_ret     = (bus.update_sel == SEL_RET);
        fallback   = bus.alu_f & ~XLEN'(1);
        ret_addr   = cur_q + STEP_V;
        target     = cur_q;
        case (bus.update_sel)
            SEL_STEP: target = cur_q + STEP_V;
            SEL_JP_R: target = cur_q + bus.offset;
            SEL_JP_F: target = fallback;
            SEL_RET:  target = ras_empty ? fallback : ras_q[top_idx];
            default:  target = cur_q;
        endcase
        misaligned = ((target & AMASK) != '0);
    end

    // Prioritised next-state: trap, stall, misalign, then redirect with RAS update.
    always_comb begin
        cur_d   = cur_q;
        next_d  = next_q;
        exc_d   = 1'b0;
        maddr_d = maddr_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ras_d   = ras_q;
        if (bus.trap_req) begin
            cur_d  = bus.trap_vec;
            next_d = bus.trap_vec + STEP_V;
        end else if (!bus.pc_write) begin
            cur_d = cur_q;
        end else if (misaligned) begin
            exc_d   = 1'b1;
            maddr_d = target;
        end else begin
            cur_d  = target;
            next_d = target + STEP_V;
            // A push+pop on an empty stack degenerates to a plain push.
            if (bus.ras_push && (!is_ret || ras_empty)) begin
                ras_d[ptr_q] = ret_addr;
                ptr_d        = ptr_q + PW'(1);
                if (count_q != CW'(RAS_DEPTH)) begin
                    count_d = count_q + CW'(1);
                end
            end else if (bus.ras_push && is_ret) begin
                ras_d[top_idx] = ret_addr;
            end else if (is_ret && !ras_empty) begin
                ptr_d   = top_idx;
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q   <= RESET_VECTOR;
            next_q  <= RESET_VECTOR + STEP_V;
            exc_q   <= 1'b0;
            maddr_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            ras_q   <= '{default: '0};
        end else begin
            cur_q   <= cur_d;
            next_q  <= next_d;
            exc_q   <= exc_d;
            maddr_q <= maddr_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ras_q   <= ras_d;
        end
    end

    assign bus.cur_inst_addr  = cur_q;
    assign bus.next_inst_addr = next_q;
    assign bus.misalign_exc   = exc_q;
    assign bus.misalign_addr  = maddr_q;
    assign bus.ras_count      = count_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard testbench for pc_gen
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(32), .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        string       nm;
        logic [31:0] cur;
        logic        exc;
        logic [31:0] maddr;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk({e.nm, ".cur"},   bus.cur_inst_addr,          e.cur);
        chk({e.nm, ".next"},  bus.next_inst_addr,         e.cur + 32'd4);
        chk({e.nm, ".exc"},   {31'd0, bus.misalign_exc},  {31'd0, e.exc});
        chk({e.nm, ".maddr"}, bus.misalign_addr,          e.maddr);
        chk({e.nm, ".cnt"},   {29'd0, bus.ras_count},     {29'd0, e.cnt});
    endtask

    // Drive one request at the falling edge and queue the state expected after the next rising edge.
    task automatic cyc(input string nm, input logic [2:0] sel, input logic pw,
                       input logic [31:0] off, input logic [31:0] alu, input logic push,
                       input logic trap, input logic [31:0] tv,
                       input logic [31:0] e_cur, input logic e_exc,
                       input logic [31:0] e_ma, input logic [2:0] e_cnt);
        exp_t e;
        @(negedge clk);
        bus.update_sel = sel;
        bus.pc_write   = pw;
        bus.offset     = off;
        bus.alu_f      = alu;
        bus.ras_push   = push;
        bus.trap_req   = trap;
        bus.trap_vec   = tv;
        e.nm = nm; e.cur = e_cur; e.exc = e_exc; e.maddr = e_ma; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t r;
        bus.update_sel = 3'd3; bus.pc_write = 1'b0; bus.offset = '0; bus.alu_f = '0;
        bus.ras_push = 1'b0; bus.trap_req = 1'b0; bus.trap_vec = '0;
        repeat (2) @(negedge clk);
        r.nm = "reset"; r.cur = 32'h0; r.exc = 1'b0; r.maddr = 32'h0; r.cnt = 3'd0;
        chk_all(r);
        rst = 1'b1;

        //    name       sel   pw  offset        alu_f         push trap trap_vec      cur           exc  maddr         cnt
        cyc("first",    3'd3, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_0000, 0, 32'h0,        3'd0);
        cyc("step1",    3'd0, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_0004, 0, 32'h0,        3'd0);
        cyc("step2",    3'd0, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_0008, 0, 32'h0,        3'd0);
        cyc("step3",    3'd0, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_000C, 0, 32'h0,        3'd0);
        cyc("jpf100",   3'd2, 1, 32'h0,        32'h100,      0,   0,   32'h0,        32'h0000_0100, 0, 32'h0,        3'd0);
        cyc("jpr_neg",  3'd1, 1, 32'hFFFF_FFF0, 32'h0,       0,   0,   32'h0,        32'h0000_00F0, 0, 32'h0,        3'd0);
        cyc("jpf_mis",  3'd2, 1, 32'h0,        32'h203,      0,   0,   32'h0,        32'h0000_00F0, 1, 32'h202,      3'd0);
        cyc("mis_drop", 3'd3, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_00F0, 0, 32'h202,      3'd0);
        cyc("to10",     3'd2, 1, 32'h0,        32'h10,       0,   0,   32'h0,        32'h0000_0010, 0, 32'h202,      3'd0);
        cyc("push1",    3'd2, 1, 32'h0,        32'h20,       1,   0,   32'h0,        32'h0000_0020, 0, 32'h202,      3'd1);
        cyc("push2",    3'd2, 1, 32'h0,        32'h30,       1,   0,   32'h0,        32'h0000_0030, 0, 32'h202,      3'd2);
        cyc("push3",    3'd2, 1, 32'h0,        32'h40,       1,   0,   32'h0,        32'h0000_0040, 0, 32'h202,      3'd3);
        cyc("push4",    3'd2, 1, 32'h0,        32'h50,       1,   0,   32'h0,        32'h0000_0050, 0, 32'h202,      3'd4);
        cyc("push5",    3'd2, 1, 32'h0,        32'h60,       1,   0,   32'h0,        32'h0000_0060, 0, 32'h202,      3'd4);
        cyc("stall",    3'd4, 0, 32'h0,        32'h700,      1,   0,   32'h0,        32'h0000_0060, 0, 32'h202,      3'd4);
        cyc("trap",     3'd4, 0, 32'h0,        32'h700,      1,   1,   32'h8000_0000, 32'h8000_0000, 0, 32'h202,     3'd4);
        cyc("ret1",     3'd4, 1, 32'h0,        32'h901,      0,   0,   32'h0,        32'h0000_0054, 0, 32'h202,      3'd3);
        cyc("ret2",     3'd4, 1, 32'h0,        32'h901,      0,   0,   32'h0,        32'h0000_0044, 0, 32'h202,      3'd2);
        cyc("ret3",     3'd4, 1, 32'h0,        32'h901,      0,   0,   32'h0,        32'h0000_0034, 0, 32'h202,      3'd1);
        cyc("ret4",     3'd4, 1, 32'h0,        32'h901,      0,   0,   32'h0,        32'h0000_0024, 0, 32'h202,      3'd0);
        cyc("ret_fb",   3'd4, 1, 32'h0,        32'h901,      0,   0,   32'h0,        32'h0000_0900, 0, 32'h202,      3'd0);
        cyc("pp_empty", 3'd4, 1, 32'h0,        32'h800,      1,   0,   32'h0,        32'h0000_0800, 0, 32'h202,      3'd1);
        cyc("pp_full",  3'd4, 1, 32'h0,        32'h700,      1,   0,   32'h0,        32'h0000_0904, 0, 32'h202,      3'd1);
        cyc("ret_new",  3'd4, 1, 32'h0,        32'h700,      0,   0,   32'h0,        32'h0000_0804, 0, 32'h202,      3'd0);
        cyc("jpr_mis",  3'd1, 1, 32'h2,        32'h0,        1,   0,   32'h0,        32'h0000_0804, 1, 32'h806,      3'd0);
        cyc("jpr_mis2", 3'd1, 1, 32'h6,        32'h0,        0,   0,   32'h0,        32'h0000_0804, 1, 32'h80A,      3'd0);
        cyc("mis_end",  3'd3, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_0804, 0, 32'h80A,      3'd0);
        cyc("to_top",   3'd2, 1, 32'h0,        32'hFFFF_FFFC, 0,  0,   32'h0,        32'hFFFF_FFFC, 0, 32'h80A,      3'd0);
        cyc("wrap",     3'd0, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_0000, 0, 32'h80A,      3'd0);
        cyc("reserved", 3'd5, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_0000, 0, 32'h80A,      3'd0);
        cyc("jpr40",    3'd1, 1, 32'h40,       32'h0,        0,   0,   32'h0,        32'h0000_0040, 0, 32'h80A,      3'd0);
        cyc("stall2",   3'd1, 0, 32'h40,       32'h0,        0,   0,   32'h0,        32'h0000_0040, 0, 32'h80A,      3'd0);

        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        r.nm = "async_rst"; r.cur = 32'h0; r.exc = 1'b0; r.maddr = 32'h0; r.cnt = 3'd0;
        chk_all(r);
        @(negedge clk);
        rst = 1'b1;
        cyc("post_rst", 3'd0, 1, 32'h0,        32'h0,        0,   0,   32'h0,        32'h0000_0004, 0, 32'h0,        3'd0);

        @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
